usb_out_ep_buffer: RTL and testbench
====================================

USB_OUT_EP_BUFFER -- requirements
Module: usb_out_ep_buffer

Interface
REQ-001 SHALL have parameter MAX_PKT, default 64, meaning buffer depth in bytes (largest accepted packet).
REQ-002 SHALL have clk, input, 1, the block's only clock.
REQ-003 SHALL have reset, input, 1, synchronous active-high reset sampled on rising clk.
REQ-004 SHALL have rx_pkt_start, input, 1, one-cycle pulse: DATA packet addressed to this endpoint begins.
REQ-005 SHALL have rx_setup, input, 1, token was SETUP; valid with rx_pkt_start.
REQ-006 SHALL have rx_toggle, input, 1, PID toggle (0=DATA0, 1=DATA1); valid with rx_pkt_start.
REQ-007 SHALL have rx_data_put, input, 1, rx_data valid this cycle.
REQ-008 SHALL have rx_data, input, 8, received payload byte.
REQ-009 SHALL have rx_pkt_end, input, 1, one-cycle pulse: packet finished.
REQ-010 SHALL have rx_pkt_valid, input, 1, CRC good; valid with rx_pkt_end.
REQ-011 SHALL have rx_ready, output, 1, endpoint can accept data (protocol engine ACKs when 1, NAKs when 0).
REQ-012 SHALL have rx_stall, output, 1, endpoint halted (protocol engine answers STALL to non-SETUP).
REQ-013 SHALL have out_ep_req, output, 1, buffered bytes pending for consumer.
REQ-014 SHALL have out_ep_grant, input, 1, consumer granted read access.
REQ-015 SHALL have out_ep_data_avail, output, 1, at least one unread byte in committed packet.
REQ-016 SHALL have out_ep_setup, output, 1, committed packet came from a SETUP token.
REQ-017 SHALL have out_ep_data_get, input, 1, consumer read request.
REQ-018 SHALL have out_ep_data, output, 8, registered read data.
REQ-019 SHALL have out_ep_stall, input, 1, consumer requests endpoint halt.
REQ-020 SHALL have out_ep_acked, output, 1, one-cycle pulse: new packet committed and ACKed.

Function
REQ-021 SHALL implement states READY, PUT, GET.
REQ-022 READY: rx_pkt_start with (rx_setup or !rx_stall) SHALL enter PUT, clear wr_ptr and overflow flag, latch setup and toggle; non-SETUP start while stalled SHALL be ignored.
REQ-023 PUT: each rx_data_put SHALL write buf[wr_ptr] and increment wr_ptr; a put with wr_ptr==MAX_PKT SHALL set overflow and not write.
REQ-024 PUT on rx_pkt_end with rx_pkt_valid, !overflow, and (setup or toggle==expected_toggle) SHALL commit: pkt_len<=wr_ptr, rd_ptr<=0, enter GET, pulse out_ep_acked next cycle.
REQ-025 Commit SHALL set expected_toggle to 1 for SETUP, else invert it.
REQ-026 Valid non-SETUP packet with toggle mismatch (retry) SHALL return to READY without out_ep_acked or toggle change.
REQ-027 rx_pkt_valid=0 or overflow at rx_pkt_end SHALL return to READY, discarding data, toggle unchanged.
REQ-028 rx_pkt_start with rx_setup SHALL, in any state, abort current packet/readout, clear stall, and enter PUT.
REQ-029 rx_ready SHALL be 1 in READY when !rx_stall, and 0 in PUT and GET.
REQ-030 GET: out_ep_data_avail and out_ep_req SHALL equal (rd_ptr < pkt_len).
REQ-031 out_ep_data_get & out_ep_grant & data_avail SHALL load out_ep_data<=buf[rd_ptr] on that edge and increment rd_ptr (data valid one cycle after request).
REQ-032 GET with rd_ptr==pkt_len SHALL return to READY next cycle; zero-length packet SHALL pass through GET for one cycle with out_ep_data_avail never asserted.
REQ-033 out_ep_setup SHALL hold latched setup flag from commit until next accepted rx_pkt_start.
REQ-034 out_ep_stall=1 SHALL set rx_stall; only SETUP start or reset clears it.
REQ-035 rd_ptr, wr_ptr, pkt_len SHALL be $clog2(MAX_PKT)+1 bits, no wrap.

Reset
REQ-036 Reset SHALL force READY, pointers/pkt_len 0, expected_toggle 0, rx_stall 0, rx_ready 1, out_ep_req/avail/setup/acked 0, out_ep_data 0, aborting any transfer.

Verification
REQ-037 SETUP bytes 80 06 00 01 00 00 12 00, valid -> out_ep_acked 1 cycle, out_ep_setup=1, 8 granted gets return bytes in order one cycle late, then READY, expected_toggle=1.
REQ-038 DATA1 3 bytes committed, same DATA1 resent -> second gives no out_ep_acked, no data_avail, rx_ready returns to 1.
REQ-039 4-byte DATA0 with rx_pkt_valid=0 -> no commit, toggle unchanged, READY.
REQ-040 MAX_PKT+1 byte packet -> discarded, buffer contents beyond MAX_PKT unwritten, no ack.
REQ-041 out_ep_stall pulse -> rx_stall=1, DATA OUT ignored; subsequent SETUP clears rx_stall and commits.
REQ-042 Reset asserted mid-GET after 2 of 8 reads -> next cycle all outputs at REQ-036 values.

Source files
------------

// File: rtl/usb_out_ep_buffer.sv
`default_nettype none
// ============================================================================
// Module   : usb_out_ep_buffer
// Brief    : USB OUT endpoint packet buffer. It handles DATA0/DATA1 toggle
//            sequencing, SETUP override, stall and registered consumer readout.
// Revision : 1.0 - initial release
// ============================================================================
module usb_out_ep_buffer #(
    parameter int MAX_PKT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_pkt_start,
    input  logic       rx_setup,
    input  logic       rx_toggle,
    input  logic       rx_data_put,
    input  logic [7:0] rx_data,
    input  logic       rx_pkt_end,
    input  logic       rx_pkt_valid,
    output logic       rx_ready,
    output logic       rx_stall,
    output logic       out_ep_req,
    input  logic       out_ep_grant,
    output logic       out_ep_data_avail,
    output logic       out_ep_setup,
    input  logic       out_ep_data_get,
    output logic [7:0] out_ep_data,
    input  logic       out_ep_stall,
    output logic       out_ep_acked
);

    localparam int              c_AW      = $clog2(MAX_PKT);
    localparam int              c_PW      = c_AW + 1;
    localparam logic [c_PW-1:0] c_MAX_PTR = c_PW'(MAX_PKT);
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

    localparam logic [1:0] c_READY = 2'd0;
    localparam logic [1:0] c_PUT   = 2'd1;
    localparam logic [1:0] c_GET   = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_pkt_len;
    logic            r_overflow;
    logic            r_setup;
    logic            r_toggle;
    logic            r_exp_toggle;
    logic            r_stall;
    logic            r_out_setup;
    logic            r_acked;
    logic [7:0]      r_out_data;
    logic [7:0]      r_buf [0:MAX_PKT-1];

    logic w_setup_start;
    logic w_accept_start;
    logic w_put;
    logic w_full;
    logic w_ovf;
    logic w_end;
    logic w_commit;
    logic w_read;

    // A SETUP token always wins: it aborts whatever is in progress.
    assign w_setup_start  = rx_pkt_start & rx_setup;
    assign w_accept_start = w_setup_start |
                            (rx_pkt_start & ~r_stall & (r_state == c_READY));
    assign w_put          = (r_state == c_PUT) & rx_data_put & ~w_setup_start;
    assign w_full         = (r_wr_ptr == c_MAX_PTR);
    assign w_ovf          = r_overflow | (w_put & w_full);
    assign w_end          = (r_state == c_PUT) & rx_pkt_end & ~w_setup_start;
    assign w_commit       = w_end & rx_pkt_valid & ~w_ovf &
                            (r_setup | (r_toggle == r_exp_toggle));
    assign w_read         = out_ep_data_avail & out_ep_data_get & out_ep_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_READY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_accept_start) begin
            w_next_state = c_PUT;
        end else begin
            case (r_state)
                c_READY: w_next_state = c_READY;
                c_PUT: begin
                    if (w_end) begin
                        w_next_state = w_commit ? c_GET : c_READY;
                    end
                end
                c_GET: begin
                    if (r_rd_ptr == r_pkt_len) begin
                        w_next_state = c_READY;
                    end
                end
                default: w_next_state = c_READY;
            endcase
        end
    end

    always_comb begin
        rx_ready          = 1'b0;
        out_ep_data_avail = 1'b0;
        out_ep_req        = 1'b0;
        case (r_state)
            c_READY: rx_ready = ~r_stall;
            c_GET: begin
                out_ep_data_avail = (r_rd_ptr < r_pkt_len);
                out_ep_req        = (r_rd_ptr < r_pkt_len);
            end
            default: begin
                rx_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pkt_len    <= '0;
            r_overflow   <= 1'b0;
            r_setup      <= 1'b0;
            r_toggle     <= 1'b0;
            r_exp_toggle <= 1'b0;
            r_stall      <= 1'b0;
            r_out_setup  <= 1'b0;
            r_acked      <= 1'b0;
            r_out_data   <= 8'h00;
        end else begin
            r_acked <= w_commit;

            if (w_setup_start) begin
                r_stall <= 1'b0;
            end else if (out_ep_stall) begin
                r_stall <= 1'b1;
            end

            if (w_accept_start) begin
                r_wr_ptr    <= '0;
                r_overflow  <= 1'b0;
                r_setup     <= rx_setup;
                r_toggle    <= rx_toggle;
                r_out_setup <= 1'b0;
            end else if (w_put) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
            end

            // SETUP resynchronises the host to DATA1 for the following stage.
            if (w_commit) begin
                r_pkt_len    <= r_wr_ptr;
                r_rd_ptr     <= '0;
                r_out_setup  <= r_setup;
                r_exp_toggle <= r_setup ? 1'b1 : ~r_exp_toggle;
            end

            if (w_read) begin
                r_out_data <= r_buf[r_rd_ptr[c_AW-1:0]];
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_put && !w_full) begin
            r_buf[r_wr_ptr[c_AW-1:0]] <= rx_data;
        end
    end

    assign rx_stall     = r_stall;
    assign out_ep_setup = r_out_setup;
    assign out_ep_acked = r_acked;
    assign out_ep_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_usb_out_ep_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_out_ep_buffer
// Brief    : Directed packet-vector bench for usb_out_ep_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_out_ep_buffer;

    localparam int c_MAX = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_pkt_start = 1'b0;
    logic       rx_setup = 1'b0;
    logic       rx_toggle = 1'b0;
    logic       rx_data_put = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_pkt_end = 1'b0;
    logic       rx_pkt_valid = 1'b0;
    logic       rx_ready;
    logic       rx_stall;
    logic       out_ep_req;
    logic       out_ep_grant = 1'b0;
    logic       out_ep_data_avail;
    logic       out_ep_setup;
    logic       out_ep_data_get = 1'b0;
    logic [7:0] out_ep_data;
    logic       out_ep_stall = 1'b0;
    logic       out_ep_acked;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt [0:127];

    typedef struct {
        logic setup;
        logic toggle;
        int   nbytes;
        logic valid;
        logic exp_ack;
    } vec_t;

    vec_t vecs [0:7];

    usb_out_ep_buffer #(.MAX_PKT(c_MAX)) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_pkt_start      (rx_pkt_start),
        .rx_setup          (rx_setup),
        .rx_toggle         (rx_toggle),
        .rx_data_put       (rx_data_put),
        .rx_data           (rx_data),
        .rx_pkt_end        (rx_pkt_end),
        .rx_pkt_valid      (rx_pkt_valid),
        .rx_ready          (rx_ready),
        .rx_stall          (rx_stall),
        .out_ep_req        (out_ep_req),
        .out_ep_grant      (out_ep_grant),
        .out_ep_data_avail (out_ep_data_avail),
        .out_ep_setup      (out_ep_setup),
        .out_ep_data_get   (out_ep_data_get),
        .out_ep_data       (out_ep_data),
        .out_ep_stall      (out_ep_stall),
        .out_ep_acked      (out_ep_acked)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(input int base, input int n);
        for (int i = 0; i < n; i++) pkt[i] = 8'((base + i * 3 + 1) & 8'hff);
    endtask

    task automatic send_pkt(input logic s, input logic t, input int n, input logic v);
        rx_pkt_start = 1'b1;
        rx_setup     = s;
        rx_toggle    = t;
        tick();
        rx_pkt_start = 1'b0;
        rx_setup     = 1'b0;
        rx_toggle    = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_data_put = 1'b1;
            rx_data     = pkt[i];
            tick();
        end
        rx_data_put  = 1'b0;
        rx_pkt_end   = 1'b1;
        rx_pkt_valid = v;
        tick();
        rx_pkt_end   = 1'b0;
        rx_pkt_valid = 1'b0;
    endtask

    task automatic read_all(input int n);
        out_ep_grant    = 1'b1;
        out_ep_data_get = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("avail_before_get", out_ep_data_avail, 1);
            chk("req_before_get", out_ep_req, 1);
            tick();
            chk($sformatf("rd_byte_%0d", i), out_ep_data, pkt[i]);
        end
        out_ep_grant    = 1'b0;
        out_ep_data_get = 1'b0;
        chk("avail_after_last", out_ep_data_avail, 0);
        chk("ready_in_get", rx_ready, 0);
        tick();
        chk("ready_after_get", rx_ready, 1);
    endtask

    // Called just after the rx_pkt_end edge.
    task automatic finish_pkt(input logic exp_ack, input logic exp_setup, input int n);
        chk("acked", out_ep_acked, exp_ack);
        if (exp_ack) begin
            chk("setup_flag", out_ep_setup, exp_setup);
            chk("avail_at_ack", out_ep_data_avail, (n > 0));
            tick();
            chk("acked_one_cycle", out_ep_acked, 0);
            if (n > 0) begin
                read_all(n);
            end else begin
                chk("zlp_avail", out_ep_data_avail, 0);
                chk("zlp_ready", rx_ready, 1);
            end
        end else begin
            chk("no_ack_ready", rx_ready, 1);
            chk("no_ack_avail", out_ep_data_avail, 0);
            tick();
            chk("no_ack_later", out_ep_acked, 0);
        end
    endtask

    initial begin
        vecs[0] = '{setup: 1'b0, toggle: 1'b0, nbytes: 3,  valid: 1'b1, exp_ack: 1'b1};
        vecs[1] = '{setup: 1'b0, toggle: 1'b0, nbytes: 3,  valid: 1'b1, exp_ack: 1'b0};
        vecs[2] = '{setup: 1'b0, toggle: 1'b1, nbytes: 5,  valid: 1'b0, exp_ack: 1'b0};
        vecs[3] = '{setup: 1'b0, toggle: 1'b1, nbytes: 2,  valid: 1'b1, exp_ack: 1'b1};
        vecs[4] = '{setup: 1'b0, toggle: 1'b0, nbytes: 64, valid: 1'b1, exp_ack: 1'b1};
        vecs[5] = '{setup: 1'b0, toggle: 1'b1, nbytes: 65, valid: 1'b1, exp_ack: 1'b0};
        vecs[6] = '{setup: 1'b1, toggle: 1'b0, nbytes: 4,  valid: 1'b1, exp_ack: 1'b1};
        vecs[7] = '{setup: 1'b0, toggle: 1'b1, nbytes: 1,  valid: 1'b1, exp_ack: 1'b1};

        repeat (3) tick();
        chk("rst_ready", rx_ready, 1);
        chk("rst_stall", rx_stall, 0);
        chk("rst_req", out_ep_req, 0);
        chk("rst_avail", out_ep_data_avail, 0);
        chk("rst_setup", out_ep_setup, 0);
        chk("rst_acked", out_ep_acked, 0);
        chk("rst_data", out_ep_data, 0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) begin
            fill(k * 16, vecs[k].nbytes);
            send_pkt(vecs[k].setup, vecs[k].toggle, vecs[k].nbytes, vecs[k].valid);
            finish_pkt(vecs[k].exp_ack, vecs[k].setup, vecs[k].nbytes);
        end

        // Standard GET_DESCRIPTOR SETUP; toggle now expected DATA1.
        pkt[0] = 8'h80; pkt[1] = 8'h06; pkt[2] = 8'h00; pkt[3] = 8'h01;
        pkt[4] = 8'h00; pkt[5] = 8'h00; pkt[6] = 8'h12; pkt[7] = 8'h00;
        send_pkt(1'b1, 1'b0, 8, 1'b1);
        finish_pkt(1'b1, 1'b1, 8);

        // DATA1 committed, then the identical retry is dropped.
        fill(200, 3);
        send_pkt(1'b0, 1'b1, 3, 1'b1);
        finish_pkt(1'b1, 1'b0, 3);
        send_pkt(1'b0, 1'b1, 3, 1'b1);
        finish_pkt(1'b0, 1'b0, 3);

        // Bad CRC leaves the toggle at DATA0, so the next DATA0 commits.
        fill(90, 4);
        send_pkt(1'b0, 1'b0, 4, 1'b0);
        finish_pkt(1'b0, 1'b0, 4);
        send_pkt(1'b0, 1'b0, 2, 1'b1);
        finish_pkt(1'b1, 1'b0, 2);

        // Zero-length DATA1.
        send_pkt(1'b0, 1'b1, 0, 1'b1);
        finish_pkt(1'b1, 1'b0, 0);

        // Stall: DATA OUT ignored until a SETUP arrives.
        out_ep_stall = 1'b1;
        tick();
        out_ep_stall = 1'b0;
        chk("stall_set", rx_stall, 1);
        chk("stall_not_ready", rx_ready, 0);
        fill(40, 3);
        send_pkt(1'b0, 1'b0, 3, 1'b1);
        chk("stall_no_ack", out_ep_acked, 0);
        chk("stall_held", rx_stall, 1);
        chk("stall_no_avail", out_ep_data_avail, 0);
        tick();
        chk("stall_no_ack_late", out_ep_acked, 0);

        fill(150, 8);
        send_pkt(1'b1, 1'b0, 8, 1'b1);
        chk("setup_clears_stall", rx_stall, 0);
        chk("stall_setup_ack", out_ep_acked, 1);
        chk("stall_setup_flag", out_ep_setup, 1);
        tick();

        // Reset in the middle of readout.
        out_ep_grant    = 1'b1;
        out_ep_data_get = 1'b1;
        tick();
        chk("mid_rd0", out_ep_data, pkt[0]);
        tick();
        chk("mid_rd1", out_ep_data, pkt[1]);
        out_ep_grant    = 1'b0;
        out_ep_data_get = 1'b0;
        reset = 1'b1;
        tick();
        chk("mrst_ready", rx_ready, 1);
        chk("mrst_stall", rx_stall, 0);
        chk("mrst_req", out_ep_req, 0);
        chk("mrst_avail", out_ep_data_avail, 0);
        chk("mrst_setup", out_ep_setup, 0);
        chk("mrst_acked", out_ep_acked, 0);
        chk("mrst_data", out_ep_data, 0);
        reset = 1'b0;
        tick();

        // Toggle back to DATA0 after reset.
        fill(7, 2);
        send_pkt(1'b0, 1'b0, 2, 1'b1);
        finish_pkt(1'b1, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
